// File: rtl/adder64_issue_stage.sv
// adder64_issue_stage
//   Operand issue/capture stage wrapped around an external combinational
//   WIDTH-bit carry-look-ahead adder. Operand pairs arrive on a valid/ready
//   port and queue in a DEPTH-entry FIFO. The FIFO head drives the adder. The
//   adder's sum/carry are captured into a result register, which is offered
//   downstream on a second valid/ready port. A chained operation takes its
//   carry-in from the carry-out of the previously captured result, so wide
//   adds can be split into multiple words.
//
//   Handshake rule (both ports): a transfer happens on a rising edge where
//   valid & ready are both 1. After valid rises it holds until that transfer.
//   in_ready depends only on registered state.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     operand port handshake
//   in_a, in_b            operands
//   in_cin                explicit carry-in (used when in_chain = 0)
//   in_chain              1: carry-in = carry-out of previous captured op
//   add_a/add_b/add_cin   drive the adder from the FIFO head (0 when empty)
//   add_s/add_cout        adder result (combinational from add_*)
//   out_valid/out_ready   result port handshake
//   out_sum, out_cout     registered result
//   op_count              results captured since reset (wraps)
module adder64_issue_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    // Operand storage; not reset, since nothing reads an empty FIFO entry.
    logic [WIDTH-1:0] mem_a     [DEPTH];
    logic [WIDTH-1:0] mem_b     [DEPTH];
    logic             mem_cin   [DEPTH];
    logic             mem_chain [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             carry_q;

    logic push;
    logic not_empty;
    logic fire;

    assign in_ready  = (count != FULL);
    assign push      = in_valid & in_ready;
    assign not_empty = (count != '0);
    // Capture whenever there is an operand and the result register is
    // empty or being drained this same cycle.
    assign fire      = not_empty & (~out_valid | out_ready);

    // Adder drive: zeros when empty so the adder sees stable known values.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (not_empty) begin
            add_a   = mem_a[rd_ptr];
            add_b   = mem_b[rd_ptr];
            add_cin = mem_chain[rd_ptr] ? carry_q : mem_cin[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]     <= in_a;
            mem_b[wr_ptr]     <= in_b;
            mem_cin[wr_ptr]   <= in_cin;
            mem_chain[wr_ptr] <= in_chain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            op_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (fire) begin
                out_sum   <= add_s;
                out_cout  <= add_cout;
                carry_q   <= add_cout;
                op_count  <= op_count + 1'b1;
                out_valid <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
